a2d_arbiter: RTL and testbench
==============================

Name: a2d_arbiter

Overview:
- Shares the single A2D converter interface between two requesters:
  - port 0: motion controller (IR sensor channels);
  - port 1: auxiliary monitor (battery/spare channels).
- Serialises conversions, forwards channel select and start strobe, and returns each result to its owner.
- Enforces an inter-conversion settle gap so the SPI link idles between transactions.
- Sits between requesters and the A2D interface block; the A2D interface itself is unchanged.

Parameters:
- GAP_CYCLES, 32: idle clocks enforced after each conversion completes before the next grant.
- STARVE_LIMIT, 4: consecutive port-0 grants allowed while req1 is pending before port 1 is forced.
- TIMEOUT_CYCLES, 1024: conversion watchdog limit (used only with A2D_TIMEOUT_EN).

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, asynchronous, active-low
- req0  input  1  port-0 request, level; held until done0
- chnnl0  input  3  port-0 channel, stable while req0 high
- req1  input  1  port-1 request, level; held until done1
- chnnl1  input  3  port-1 channel, stable while req1 high
- gnt0  output  1  port 0 owns converter
- gnt1  output  1  port 1 owns converter
- done0  output  1  one-cycle pulse: port-0 result valid
- done1  output  1  one-cycle pulse: port-1 result valid
- res  output  12  last conversion result, held until next completion
- err  output  1  qualifies done: conversion timed out
- busy  output  1  high in any state except IDLE
- strt_cnv  output  1  one-cycle start strobe to A2D interface
- chnnl  output  3  channel to A2D interface, registered
- cnv_cmplt  input  1  A2D conversion-complete pulse
- A2D_res  input  12  A2D result, valid with cnv_cmplt

Behaviour:
- Reset: rst_n=0 forces the following, immediately (async) and from any state, with any in-flight conversion abandoned:
  - state=IDLE;
  - gnt0, gnt1, done0, done1, err, strt_cnv, busy = 0;
  - chnnl=0, res=0;
  - gap timer, starvation counter and watchdog cleared.
- States: IDLE, START, CONV, GAP.
- IDLE:
  - When req0|req1 is sampled at an edge, pick the winner, register chnnl from the winner's chnnl input, set the winner's gnt, and move to START at the same edge.
  - No request: remain in IDLE.
- Arbitration (evaluated in IDLE only):
  - If only one port requests, that port wins.
  - If both request, port 0 wins, unless starve_cnt==STARVE_LIMIT, in which case port 1 wins.
  - starve_cnt increments on each port-0 grant made while req1=1.
  - starve_cnt clears on any port-1 grant, and whenever req1=0 in IDLE.
  - starve_cnt saturates at STARVE_LIMIT.
- START: strt_cnv=1 for exactly this one cycle; chnnl is already stable from the prior edge. Next state is CONV.
- CONV:
  - Wait for cnv_cmplt.
  - On the edge where cnv_cmplt=1: res<=A2D_res; the owner's done pulses high for the next cycle; err<=0; gap timer loads GAP_CYCLES; state moves to GAP.
  - gnt stays high through the done cycle and drops the following edge.
- cnv_cmplt outside CONV is ignored; res is not updated.
- GAP:
  - Timer decrements once per clock.
  - Move to IDLE in the cycle after the timer reaches 0.
  - Requests arriving in GAP are held off, not lost, because requests are level-sensitive.
- Latency:
  - req sampled at edge T gives strt_cnv high in cycle T+1.
  - cnv_cmplt at edge C gives done/res valid in cycle C+1.
  - Earliest next strt_cnv is GAP_CYCLES+3 cycles after done.
- Requester protocol:
  - A requester deasserts req in the cycle after done.
  - If req is still high when IDLE is re-entered, it is treated as a new request.
  - If req is dropped mid-conversion, the conversion still completes and done still pulses; the requester discards the result.
  - If chnnl changes while granted, it is ignored; chnnl is latched at grant.
- Only one gnt is ever high; done0 and done1 are never high together.

Optional Feature:
- Macro: A2D_TIMEOUT_EN.
- Defined:
  - A watchdog counts cycles in CONV.
  - If TIMEOUT_CYCLES elapse with no cnv_cmplt: owner's done pulses with err=1, res<=12'h000, gap timer loads, state moves to GAP.
  - The watchdog clears on entry to START.
- Undefined: no watchdog logic; CONV waits indefinitely; err tied to 0.

Test Plan:
- Single request: req1=1, chnnl1=3'h5; cnv_cmplt 40 cycles later with A2D_res=12'hABC -> strt_cnv one cycle after grant, chnnl=5, done1 one cycle after cnv_cmplt, res=12'hABC, gnt0 never high.
- Collision: req0 (chnnl0=1) and req1 (chnnl1=6) rise in the same cycle -> port 0 served first with chnnl=1; port 1 served next with chnnl=6, and its strt_cnv comes no earlier than GAP_CYCLES+3 cycles after done0.
- Starvation: req0 re-asserted continuously with req1 held high -> grant sequence 0,0,0,0,1,0,... (port 1 forced on the 5th grant).
- Gap enforcement: req0 re-asserted the cycle after done0 -> no strt_cnv for 32 cycles; busy stays high through the gap.
- Reset mid-conversion: rst_n low while in CONV with gnt0=1 -> all outputs 0 immediately; a later cnv_cmplt produces no done.
- With A2D_TIMEOUT_EN: no cnv_cmplt for 1024 cycles -> done0=1, err=1, res=12'h000, then GAP.

Source files
------------

// File: rtl/a2d_arbiter_if.sv
// rtl/a2d_arbiter_if.sv - requester and A2D-side signal bundle for a2d_arbiter
interface a2d_arbiter_if;
    logic        req0;
    logic [2:0]  chnnl0;
    logic        req1;
    logic [2:0]  chnnl1;
    logic        gnt0;
    logic        gnt1;
    logic        done0;
    logic        done1;
    logic [11:0] res;
    logic        err;
    logic        busy;
    logic        strt_cnv;
    logic [2:0]  chnnl;
    logic        cnv_cmplt;
    logic [11:0] A2D_res;

    modport master (
        output req0, chnnl0, req1, chnnl1, cnv_cmplt, A2D_res,
        input  gnt0, gnt1, done0, done1, res, err, busy, strt_cnv, chnnl
    );

    modport slave (
        input  req0, chnnl0, req1, chnnl1, cnv_cmplt, A2D_res,
        output gnt0, gnt1, done0, done1, res, err, busy, strt_cnv, chnnl
    );
endinterface

// File: rtl/a2d_arbiter.sv
// rtl/a2d_arbiter.sv - two-port A2D conversion arbiter, optional watchdog via A2D_TIMEOUT_EN
module a2d_arbiter #(
    parameter int GAP_CYCLES     = 32,
    parameter int STARVE_LIMIT   = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic         clk,
    input  logic         rst_n,
    a2d_arbiter_if.slave bus
);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [GW-1:0] GAP_LOAD   = GW'(GAP_CYCLES);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, START, CONV, GAP} state_t;

    state_t        state_q, state_d;
    logic          gnt0_q, gnt0_d;
    logic          gnt1_q, gnt1_d;
    logic          done0_q, done0_d;
    logic          done1_q, done1_d;
    logic [2:0]    chnnl_q, chnnl_d;
    logic [11:0]   res_q, res_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          gap_zero_q, gap_zero_d;
    logic          pick1;

`ifdef A2D_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYCLES - 1);
    logic [WW-1:0] wd_q, wd_d;
    logic          err_q, err_d;
    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    assign bus.gnt0     = gnt0_q;
    assign bus.gnt1     = gnt1_q;
    assign bus.done0    = done0_q;
    assign bus.done1    = done1_q;
    assign bus.res      = res_q;
    assign bus.chnnl    = chnnl_q;
    assign bus.strt_cnv = (state_q == START);
    assign bus.busy     = (state_q != IDLE);

    // Next-state, arbitration and output-register values
    always_comb begin
        state_d    = state_q;
        gnt0_d     = gnt0_q;
        gnt1_d     = gnt1_q;
        done0_d    = 1'b0;
        done1_d    = 1'b0;
        chnnl_d    = chnnl_q;
        res_d      = res_q;
        starve_d   = starve_q;
        gap_d      = gap_q;
        gap_zero_d = 1'b0;
        pick1      = 1'b0;
`ifdef A2D_TIMEOUT_EN
        err_d      = 1'b0;
        wd_d       = wd_q;
`endif
        case (state_q)
            IDLE: begin
                if (!bus.req1) begin
                    starve_d = '0;
                end
                if (bus.req0 || bus.req1) begin
                    pick1   = bus.req1 && (!bus.req0 || starve_q == STARVE_MAX);
                    state_d = START;
                    if (pick1) begin
                        gnt1_d   = 1'b1;
                        chnnl_d  = bus.chnnl1;
                        starve_d = '0;
                    end else begin
                        gnt0_d  = 1'b1;
                        chnnl_d = bus.chnnl0;
                        if (bus.req1 && starve_q != STARVE_MAX) begin
                            starve_d = starve_q + 1'b1;
                        end
                    end
                end
            end
            START: begin
                state_d = CONV;
`ifdef A2D_TIMEOUT_EN
                wd_d    = '0;
`endif
            end
            CONV: begin
                if (bus.cnv_cmplt) begin
                    res_d   = bus.A2D_res;
                    done0_d = gnt0_q;
                    done1_d = gnt1_q;
                    gap_d   = GAP_LOAD;
                    state_d = GAP;
                end
`ifdef A2D_TIMEOUT_EN
                else if (wd_q == WD_LAST) begin
                    res_d   = '0;
                    done0_d = gnt0_q;
                    done1_d = gnt1_q;
                    err_d   = 1'b1;
                    gap_d   = GAP_LOAD;
                    state_d = GAP;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
`endif
            end
            GAP: begin
                // Grant is held through the done cycle, which is the first GAP cycle
                gnt0_d     = 1'b0;
                gnt1_d     = 1'b0;
                gap_zero_d = (gap_q == '0);
                if (gap_q != '0) begin
                    gap_d = gap_q - 1'b1;
                end
                // Leave one cycle after the timer has been seen at zero
                if (gap_q == '0 && gap_zero_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            gnt0_q     <= 1'b0;
            gnt1_q     <= 1'b0;
            done0_q    <= 1'b0;
            done1_q    <= 1'b0;
            chnnl_q    <= '0;
            res_q      <= '0;
            starve_q   <= '0;
            gap_q      <= '0;
            gap_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt0_q     <= gnt0_d;
            gnt1_q     <= gnt1_d;
            done0_q    <= done0_d;
            done1_q    <= done1_d;
            chnnl_q    <= chnnl_d;
            res_q      <= res_d;
            starve_q   <= starve_d;
            gap_q      <= gap_d;
            gap_zero_q <= gap_zero_d;
        end
    end

`ifdef A2D_TIMEOUT_EN
    // Conversion watchdog and error flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            wd_q  <= wd_d;
            err_q <= err_d;
        end
    end
`endif
endmodule

// File: tb/tb_a2d_arbiter.sv
// tb/tb_a2d_arbiter.sv - self-checking bench for a2d_arbiter
module tb_a2d_arbiter;
    localparam int GAP  = 32;
    localparam int TOUT = 1024;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    a2d_arbiter_if bus();

    a2d_arbiter #(
        .GAP_CYCLES    (GAP),
        .STARVE_LIMIT  (4),
        .TIMEOUT_CYCLES(TOUT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        logic        r0;
        logic [2:0]  c0;
        logic        r1;
        logic [2:0]  c1;
        int          dly;
        logic [11:0] ad;
        logic        port;
        logic [2:0]  ch;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (bus.busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(name, bus.busy, 1'b0);
    endtask

    // Wait for a grant, check it, complete the conversion two cycles later
    task automatic serve(input string name, input logic exp_port, input logic [2:0] exp_ch,
                         input logic [11:0] ad, output int t_strt, output int t_done,
                         output int busy_low);
        int n = 0;
        busy_low = 0;
        while (!bus.strt_cnv && n < 300) begin
            if (!bus.busy) busy_low++;
            @(negedge clk);
            n++;
        end
        check({name, "_strt"}, bus.strt_cnv, 1'b1);
        t_strt = cyc;
        check({name, "_gnt1"}, bus.gnt1, exp_port);
        check({name, "_gnt0"}, bus.gnt0, !exp_port);
        check({name, "_chnnl"}, bus.chnnl, exp_ch);
        repeat (2) @(negedge clk);
        bus.cnv_cmplt = 1'b1;
        bus.A2D_res   = ad;
        @(negedge clk);
        bus.cnv_cmplt = 1'b0;
        t_done = cyc;
        check({name, "_done"}, exp_port ? bus.done1 : bus.done0, 1'b1);
        check({name, "_res"}, bus.res, ad);
    endtask

    // Mutual-exclusion monitor
    always @(negedge clk) begin
        if (bus.gnt0 && bus.gnt1) begin
            total++; bad++;
            $display("FAIL gnt_exclusive: got both high expected one");
        end
        if (bus.done0 && bus.done1) begin
            total++; bad++;
            $display("FAIL done_exclusive: got both high expected one");
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int ts, td, bl, ts2, td2, n;
        logic [5:0] starve_seq;
        vec_t v;

        vecs[0] = '{r0:1'b0, c0:3'h0, r1:1'b1, c1:3'h5, dly:40, ad:12'hABC, port:1'b1, ch:3'h5};
        vecs[1] = '{r0:1'b1, c0:3'h2, r1:1'b0, c1:3'h0, dly:3,  ad:12'h123, port:1'b0, ch:3'h2};
        vecs[2] = '{r0:1'b1, c0:3'h7, r1:1'b1, c1:3'h4, dly:1,  ad:12'hFFF, port:1'b0, ch:3'h7};
        vecs[3] = '{r0:1'b0, c0:3'h0, r1:1'b1, c1:3'h0, dly:10, ad:12'h000, port:1'b1, ch:3'h0};
        vecs[4] = '{r0:1'b1, c0:3'h3, r1:1'b0, c1:3'h0, dly:2,  ad:12'h5A5, port:1'b0, ch:3'h3};

        bus.req0 = 1'b0; bus.chnnl0 = '0; bus.req1 = 1'b0; bus.chnnl1 = '0;
        bus.cnv_cmplt = 1'b0; bus.A2D_res = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_gnt0", bus.gnt0, 1'b0);
        check("rst_gnt1", bus.gnt1, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_strt", bus.strt_cnv, 1'b0);
        check("rst_res", bus.res, 12'h000);
        check("rst_chnnl", bus.chnnl, 3'h0);
        check("rst_err", bus.err, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven single transactions from IDLE
        for (int i = 0; i < 5; i++) begin
            v = vecs[i];
            bus.req0 = v.r0; bus.chnnl0 = v.c0;
            bus.req1 = v.r1; bus.chnnl1 = v.c1;
            @(negedge clk);
            check("vec_strt", bus.strt_cnv, 1'b1);
            check("vec_gnt1", bus.gnt1, v.port);
            check("vec_gnt0", bus.gnt0, !v.port);
            check("vec_chnnl", bus.chnnl, v.ch);
            bus.chnnl0 = ~v.c0; bus.chnnl1 = ~v.c1;
            for (int k = 0; k < v.dly; k++) begin
                @(negedge clk);
                if (k == 0) check("vec_strt_once", bus.strt_cnv, 1'b0);
            end
            check("vec_chnnl_latched", bus.chnnl, v.ch);
            bus.cnv_cmplt = 1'b1; bus.A2D_res = v.ad;
            @(negedge clk);
            bus.cnv_cmplt = 1'b0;
            check("vec_done0", bus.done0, !v.port);
            check("vec_done1", bus.done1, v.port);
            check("vec_res", bus.res, v.ad);
            check("vec_err", bus.err, 1'b0);
            check("vec_gnt_hold", v.port ? bus.gnt1 : bus.gnt0, 1'b1);
            bus.req0 = 1'b0; bus.req1 = 1'b0;
            @(negedge clk);
            check("vec_done_pulse", bus.done0 | bus.done1, 1'b0);
            check("vec_gnt_drop", bus.gnt0 | bus.gnt1, 1'b0);
            check("vec_busy_gap", bus.busy, 1'b1);
            wait_idle("vec_idle");
        end

        // cnv_cmplt outside CONV is ignored
        bus.cnv_cmplt = 1'b1; bus.A2D_res = 12'h321;
        @(negedge clk);
        bus.cnv_cmplt = 1'b0;
        @(negedge clk);
        check("stray_res", bus.res, 12'h5A5);
        check("stray_done", bus.done0 | bus.done1, 1'b0);
        check("stray_busy", bus.busy, 1'b0);

        // Collision: port 0 first, port 1 after the full gap
        bus.req0 = 1'b1; bus.chnnl0 = 3'h1;
        bus.req1 = 1'b1; bus.chnnl1 = 3'h6;
        @(negedge clk);
        serve("col0", 1'b0, 3'h1, 12'h111, ts, td, bl);
        @(negedge clk);
        bus.req0 = 1'b0;
        serve("col1", 1'b1, 3'h6, 12'h666, ts2, td2, bl);
        check("col_gap", ts2 - td, GAP + 3);
        @(negedge clk);
        bus.req1 = 1'b0;
        wait_idle("col_idle");

        // Gap enforcement with req0 held across done
        bus.req0 = 1'b1; bus.chnnl0 = 3'h2;
        @(negedge clk);
        serve("gap_a", 1'b0, 3'h2, 12'h0A0, ts, td, bl);
        serve("gap_b", 1'b0, 3'h2, 12'h0B0, ts2, td2, bl);
        check("gap_spacing", ts2 - td, GAP + 3);
        check("gap_busy_low", bl, 1);
        @(negedge clk);
        bus.req0 = 1'b0;
        wait_idle("gap_idle");

        // Starvation: grants 0,0,0,0,1,0
        starve_seq = 6'b010000;
        bus.req0 = 1'b1; bus.chnnl0 = 3'h2;
        bus.req1 = 1'b1; bus.chnnl1 = 3'h5;
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            serve("starve", starve_seq[i], starve_seq[i] ? 3'h5 : 3'h2,
                  12'(16 * i + 1), ts, td, bl);
            if (starve_seq[i]) begin
                @(negedge clk);
                bus.req1 = 1'b0;
            end
        end
        @(negedge clk);
        bus.req0 = 1'b0;
        wait_idle("starve_idle");

        // Reset mid-conversion
        bus.req0 = 1'b1; bus.chnnl0 = 3'h4;
        n = 0;
        @(negedge clk);
        while (!bus.strt_cnv && n < 100) begin @(negedge clk); n++; end
        check("rstc_strt", bus.strt_cnv, 1'b1);
        repeat (2) @(negedge clk);
        check("rstc_gnt0_pre", bus.gnt0, 1'b1);
        rst_n = 1'b0;
        #1;
        check("rstc_gnt0", bus.gnt0, 1'b0);
        check("rstc_busy", bus.busy, 1'b0);
        check("rstc_res", bus.res, 12'h000);
        check("rstc_chnnl", bus.chnnl, 3'h0);
        check("rstc_strt0", bus.strt_cnv, 1'b0);
        bus.req0 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus.cnv_cmplt = 1'b1; bus.A2D_res = 12'h777;
        @(negedge clk);
        bus.cnv_cmplt = 1'b0;
        check("rstc_no_done", bus.done0 | bus.done1, 1'b0);
        check("rstc_res_kept", bus.res, 12'h000);
        check("rstc_idle", bus.busy, 1'b0);

`ifdef A2D_TIMEOUT_EN
        // Watchdog expiry
        bus.req0 = 1'b1; bus.chnnl0 = 3'h3;
        n = 0;
        @(negedge clk);
        while (!bus.strt_cnv && n < 100) begin @(negedge clk); n++; end
        check("wd_strt", bus.strt_cnv, 1'b1);
        ts = cyc;
        n = 0;
        while (!bus.done0 && n < TOUT + 100) begin @(negedge clk); n++; end
        check("wd_done0", bus.done0, 1'b1);
        check("wd_err", bus.err, 1'b1);
        check("wd_res", bus.res, 12'h000);
        check("wd_latency", cyc - ts, TOUT + 1);
        bus.req0 = 1'b0;
        @(negedge clk);
        check("wd_err_pulse", bus.err, 1'b0);
        check("wd_gap_busy", bus.busy, 1'b1);
        wait_idle("wd_idle");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
